serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial N-bit subtractor computing diff = a - b - bin, one bit per clock, LSB first.
//  Each cycle, one full-subtractor cell (two cascaded half-subtractor stages) processes one bit.
//  A one-bit borrow register carries the borrow between bits.
//  Sits between an operand source (start/a/b) and any consumer of the result (done/diff/bout).
// PARAMETERS
//  N        8   operand/result width in bits; legal range 1..32
//  CNT_W    6   width of the bit counter; must satisfy 2**CNT_W > N
// PORTS
//  clk      in   1      single clock; all state updates on rising edge
//  rst      in   1      synchronous, active-high reset
//  start    in   1      request; sampled only in IDLE
//  a        in   N      minuend; captured on accepted start
//  b        in   N      subtrahend; captured on accepted start
//  bin      in   1      borrow-in; captured on accepted start
//  busy     out  1      high in RUN and DONE states
//  done     out  1      one-cycle pulse; diff and bout are valid from this cycle
//  diff     out  N      result a - b - bin, modulo 2**N
//  bout     out  1      final borrow; 1 when a < b + bin (unsigned)
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, diff=0, bout=0; shift registers, borrow flop and counter=0.
//  States:
//   IDLE: start=1 -> load a_sh=a, b_sh=b, brw=bin, cnt=0, diff_sh=0; go to RUN.
//         start=0 -> stay in IDLE.
//   RUN, each cycle:
//    - d  = a_sh[0] ^ b_sh[0] ^ brw
//    - bo = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw)
//    - diff_sh <= {d, diff_sh[N-1:1]}
//    - a_sh and b_sh shift right by one, MSB filled with 0
//    - brw <= bo, cnt <= cnt + 1
//    - cnt == N-1 -> go to DONE.
//   DONE (exactly 1 cycle): done=1, diff=diff_sh, bout=brw; go to IDLE.
//  Latency: start accepted at rising edge t -> done high in cycle t+N+1.
//  Throughput: one operation per N+2 cycles.
//  diff and bout are registered; they hold their value until the next done pulse.
//  They do not change during a following RUN.
//  start while busy=1 (RUN or DONE) is ignored and not queued. a, b, bin are don't-care outside accept.
//  Wrap-around: the result is modulo 2**N; underflow is signalled only through bout.
//  N=1: RUN lasts exactly one cycle.
//  rst during RUN or DONE: abort on that edge, all state and outputs return to reset values,
//   no done pulse. rst has priority over start in the same cycle.
//  No combinational path from any input to any output.
// STRUCTURE
//  Shared package: state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
//  Sub-module full_sub_cell (x, y, bi -> d, bo): built from two half-subtractor stages
//   with the borrows ORed. Instantiated once, combinationally, on a_sh[0], b_sh[0], brw.
//  Top level holds the FSM, counter, shift registers, borrow flop and output registers.
// TESTING
//  N=8, a=8'h5A, b=8'h3C, bin=0 -> done at cycle t+9; diff=8'h1E, bout=0.
//  N=8, a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1 (wrap-around).
//  N=8, a=8'h10, b=8'h0F, bin=1 -> diff=8'h00, bout=0; then a=b=8'hA5, bin=1 -> diff=8'hFF, bout=1.
//  start pulsed in cycle t+3 of a running op with different operands -> ignored;
//   only the first result appears and only one done pulse occurs.
//  rst asserted in cycle t+4 of an op -> next cycle busy=0, diff=0, bout=0, no done;
//   a new start afterwards completes correctly.
//  Back-to-back: start held high continuously -> ops accepted every N+2 cycles;
//   diff is stable between done pulses.
//  Exhaustive check at N=4: all a, b, bin combinations match a reference model,
//   including done timing.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_full_sub_cell.sv
// One-bit full subtractor built from two cascaded half-subtractor stages.
module half_sub (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);
  assign d  = x ^ y;
  assign bo = ~x & y;
endmodule

module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  logic d1, b1, b2;

  half_sub u_hs0 (.x(x),  .y(y),  .d(d1), .bo(b1));
  half_sub u_hs1 (.x(d1), .y(bi), .d(d),  .bo(b2));

  // At most one stage can borrow, so OR merges them.
  assign bo = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout
);

  state_e             state, state_nxt;
  logic [N-1:0]       a_sh, b_sh, diff_sh, diff_nxt;
  logic               brw;
  logic [CNT_W-1:0]   cnt;
  logic               d, bo, last;

  full_sub_cell u_cell (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .bi (brw),
    .d  (d),
    .bo (bo)
  );

  assign last     = (cnt == CNT_W'(N - 1));
  // New bit enters at the MSB so after N shifts bit 0 lands at the LSB.
  assign diff_nxt = (diff_sh >> 1) | (N'(d) << (N - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last)  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      diff_sh <= '0;
      brw     <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != ST_IDLE);
      done  <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          a_sh    <= a;
          b_sh    <= b;
          brw     <= bin;
          cnt     <= '0;
          diff_sh <= '0;
        end
        ST_RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          diff_sh <= diff_nxt;
          brw     <= bo;
          cnt     <= cnt + 1'b1;
          // Publish on the final bit so results are already valid while DONE.
          if (last) begin
            done <= 1'b1;
            diff <= diff_nxt;
            bout <= bo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and exhaustive checks of serial_subtractor against an arithmetic model.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;
  logic       start4, bin4, busy4, done4, bout4;
  logic [3:0] a4, b4, diff4;

  serial_subtractor #(.N(8), .CNT_W(6)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.N(4), .CNT_W(3)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last8 = '0, last4 = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int w, input logic s, input logic [31:0] av,
                       input logic [31:0] bv, input logic bi);
    if (w == 8) begin start8 = s; a8 = av[7:0]; b8 = bv[7:0]; bin8 = bi; end
    else        begin start4 = s; a4 = av[3:0]; b4 = bv[3:0]; bin4 = bi; end
  endtask

  function automatic logic o_busy(input int w); return (w == 8) ? busy8 : busy4; endfunction
  function automatic logic o_done(input int w); return (w == 8) ? done8 : done4; endfunction
  function automatic logic o_bout(input int w); return (w == 8) ? bout8 : bout4; endfunction
  function automatic logic [31:0] o_diff(input int w);
    return (w == 8) ? {24'd0, diff8} : {28'd0, diff4};
  endfunction

  // One operation; poke>0 pulses a spurious start, rst_at>0 aborts, both at that edge index.
  task automatic op(input int w, input logic [31:0] av, input logic [31:0] bv,
                    input logic bi, input int poke, input int rst_at);
    logic [31:0] m, ed, held, ra;
    logic        eb;
    int          done_at, pulses;
    m       = (32'd1 << w) - 1;
    ed      = (av - bv - {31'd0, bi}) & m;
    eb      = (av < bv + {31'd0, bi});
    held    = (w == 8) ? last8 : last4;
    done_at = -1;
    pulses  = 0;
    @(negedge clk);
    drive(w, 1'b1, av, bv, bi);
    @(posedge clk); #1;
    drive(w, 1'b0, ~av, ~bv, ~bi);
    chk("busy_run", {31'd0, o_busy(w)}, 32'd1);
    for (int k = 1; k <= w + 2; k++) begin
      if (k == poke) begin
        ra = $urandom;
        drive(w, 1'b1, ra, ~ra, 1'b1);
      end
      if (k == rst_at) rst = 1'b1;
      @(posedge clk); #1;
      if (k == poke) drive(w, 1'b0, 32'd0, 32'd0, 1'b0);
      if (k == rst_at) begin
        rst = 1'b0;
        chk("abort_busy", {31'd0, o_busy(w)}, 32'd0);
        chk("abort_done", {31'd0, o_done(w)}, 32'd0);
        chk("abort_diff", o_diff(w), 32'd0);
        chk("abort_bout", {31'd0, o_bout(w)}, 32'd0);
        chk("abort_pulses", pulses, 32'd0);
        if (w == 8) last8 = '0; else last4 = '0;
        return;
      end
      if (o_done(w)) begin
        pulses++;
        if (done_at < 0) begin
          done_at = k;
          chk("diff", o_diff(w), ed);
          chk("bout", {31'd0, o_bout(w)}, {31'd0, eb});
        end
      end else if (k <= w) begin
        chk("hold", o_diff(w), held);
      end
    end
    chk("latency", done_at, w);
    chk("pulses", pulses, 32'd1);
    if (w == 8) last8 = ed; else last4 = ed;
  endtask

  initial begin
    logic [31:0] ra, rb, ed, eb;
    logic        rbi;
    int          last_k, ndone;
    rst = 1'b1;
    drive(8, 1'b0, 32'd0, 32'd0, 1'b0);
    drive(4, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_diff", {24'd0, diff8}, 32'd0);
    chk("rst_bout", {31'd0, bout8}, 32'd0);
    rst = 1'b0;

    op(8, 32'h5A, 32'h3C, 1'b0, 0, 0);
    op(8, 32'h00, 32'h01, 1'b0, 0, 0);
    op(8, 32'h10, 32'h0F, 1'b1, 0, 0);
    op(8, 32'hA5, 32'hA5, 1'b1, 0, 0);
    op(8, 32'h5A, 32'h3C, 1'b0, 3, 0);
    op(8, 32'hFF, 32'h12, 1'b1, 0, 4);
    op(8, 32'h33, 32'hC4, 1'b0, 0, 0);
    op(8, 32'hFF, 32'hFF, 1'b1, 0, 0);
    op(8, 32'h00, 32'h00, 1'b0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom; rbi = ra[31];
      op(8, ra & 32'hFF, rb & 32'hFF, rbi, 0, 0);
    end

    // Back-to-back with start held high: one accept every N+2 cycles.
    @(negedge clk);
    ra = $urandom & 32'hFF; rb = $urandom & 32'hFF; rbi = ra[0];
    ed = (ra - rb - {31'd0, rbi}) & 32'hFF;
    eb = {31'd0, (ra < rb + {31'd0, rbi})};
    drive(8, 1'b1, ra, rb, rbi);
    last_k = -1;
    ndone  = 0;
    for (int k = 0; k < 70 && ndone < 5; k++) begin
      @(posedge clk); #1;
      if (done8) begin
        chk("b2b_diff", {24'd0, diff8}, ed);
        chk("b2b_bout", {31'd0, bout8}, eb);
        chk("b2b_gap", k - last_k, (last_k < 0) ? 32'd8 + 32'd1 : 32'd10);
        last_k = k;
        last8  = ed;
        ndone++;
        ra = $urandom & 32'hFF; rb = $urandom & 32'hFF; rbi = ra[1];
        ed = (ra - rb - {31'd0, rbi}) & 32'hFF;
        eb = {31'd0, (ra < rb + {31'd0, rbi})};
        if (ndone < 5) drive(8, 1'b1, ra, rb, rbi);
        else drive(8, 1'b0, 32'd0, 32'd0, 1'b0);
      end else begin
        chk("b2b_hold", {24'd0, diff8}, last8);
      end
    end
    chk("b2b_count", ndone, 32'd5);
    drive(8, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          op(4, 32'(x), 32'(y), c[0], 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
